rr_packet_arbiter: RTL and testbench

//  Shares one downstream valid/ready port between N requesters using round-robin priority.
//  A winner keeps the port for a whole multi-beat packet, until the beat with last=1.
//  The payload is steered with a one-hot select, the same way one_hot_mux does it.

---
 rtl/rr_packet_arbiter.sv | 78 +++++++
 tb/tb_rr_packet_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_packet_arbiter.sv
// rr_packet_arbiter: round-robin arbiter that holds one requester's grant until its packet's last beat
module rr_packet_arbiter #(
    parameter int N     = 4,
    parameter int NBITS = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N-1:0]       req_valid,
    input  logic [N-1:0]       req_last,
    input  logic [N*NBITS-1:0] req_data,
    output logic [N-1:0]       req_ready,
    output logic               out_valid,
    output logic               out_last,
    output logic [NBITS-1:0]   out_data,
    input  logic               out_ready,
    output logic [N-1:0]       grant,
    output logic               locked
);
    localparam int W = (N > 1) ? $clog2(N) : 1;
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] LOCK = 1'b1;

    logic [0:0]   st;
    logic [W-1:0] ptr, owner, w;
    logic [N-1:0] scan;
    logic         found, xfer;

    // explicit wrap at N so non-power-of-2 N never relies on counter overflow
    function automatic logic [W-1:0] add_mod(input logic [W-1:0] a, input int k);
        return W'((int'(a) + k) % N);
    endfunction

    always_comb begin
        scan  = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && req_valid[add_mod(ptr, k)]) begin
                scan[add_mod(ptr, k)] = 1'b1;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        w = '0;
        for (int i = 0; i < N; i++)
            if (grant[i]) w = W'(i);
    end

    always_comb begin
        out_data = '0;
        for (int i = 0; i < N; i++)
            out_data = out_data | (req_data[i*NBITS +: NBITS] & {NBITS{grant[i]}});
    end

    assign grant     = reset ? '0 : (st == LOCK ? N'(1) << owner : scan);
    assign out_valid = |(grant & req_valid);
    assign out_last  = |(grant & req_last);
    assign req_ready = grant & {N{out_ready}};
    assign xfer      = out_valid & out_ready;
    assign locked    = (st == LOCK);

    always_ff @(posedge clk) begin
        if (reset) begin
            st    <= IDLE;
            ptr   <= '0;
            owner <= '0;
        end else if (xfer) begin
            if (out_last) begin
                st  <= IDLE;
                ptr <= add_mod(w, 1);
            end else if (st == IDLE) begin
                st    <= LOCK;
                owner <= w;
            end
        end
    end
endmodule

// File: tb/tb_rr_packet_arbiter.sv
// tb_rr_packet_arbiter: directed scenarios plus randomized traffic against a priority/lock model
module tb_rr_packet_arbiter;
    localparam int N  = 4;
    localparam int NB = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      req_valid, req_last, req_ready, grant;
    logic [N*NB-1:0]   req_data;
    logic              out_valid, out_last, out_ready, locked;
    logic [NB-1:0]     out_data;

    int checks = 0;
    int failures = 0;

    int m_ptr = 0;
    int m_owner = 0;
    bit m_lock = 1'b0;

    rr_packet_arbiter #(.N(N), .NBITS(NB)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_last(req_last),
        .req_data(req_data), .req_ready(req_ready), .out_valid(out_valid),
        .out_last(out_last), .out_data(out_data), .out_ready(out_ready),
        .grant(grant), .locked(locked)
    );

    always #5 clk = ~clk;

    // owner while locked, else the valid requester closest after the priority pointer
    function automatic int m_winner();
        int best = -1;
        int best_d = N;
        if (m_lock) return m_owner;
        for (int i = 0; i < N; i++) begin
            int d = (i - m_ptr + N) % N;
            if (req_valid[i] && d < best_d) begin
                best = i;
                best_d = d;
            end
        end
        return best;
    endfunction

    function automatic logic [NB-1:0] data_of(input int i);
        return req_data[i*NB +: NB];
    endfunction

    task automatic randomize_data();
        for (int i = 0; i < N; i++) req_data[i*NB +: NB] = $urandom();
    endtask

    task automatic tick();
        int  wi = m_winner();
        bit  xf = !reset && wi >= 0 && req_valid[wi] && out_ready;
        if (reset) begin
            m_lock = 1'b0;
            m_ptr = 0;
            m_owner = 0;
        end else if (xf) begin
            if (req_last[wi]) begin
                m_lock = 1'b0;
                m_ptr = (wi + 1) % N;
            end else if (!m_lock) begin
                m_lock = 1'b1;
                m_owner = wi;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = '1; req_last = '1; out_ready = 1'b1; randomize_data();
        #1;
        checks++;
        if (grant !== 4'b0000 || out_valid !== 1'b0 || req_ready !== 4'b0000 || out_data !== '0 || out_last !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs grant=%b ready=%b valid=%b last=%b data=%h required all zero", grant, req_ready, out_valid, out_last, out_data);
        end
        tick(); tick();
        reset = 1'b0; req_valid = '0;
        #1;
        checks++;
        if (locked !== 1'b0 || grant !== 4'b0000) begin
            failures++;
            $display("FAIL reset_state locked=%b grant=%b required 0/0000", locked, grant);
        end
    endtask

    task automatic test_single();
        req_valid = 4'b0100; req_last = 4'b0100; out_ready = 1'b1; randomize_data();
        #1;
        checks++;
        if (grant !== 4'b0100 || req_ready !== 4'b0100 || out_data !== data_of(2) || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL single_req grant=%b ready=%b data=%h valid=%b required 0100/0100/%h/1", grant, req_ready, out_data, out_valid, data_of(2));
        end
        tick();
        req_valid = 4'b1111; req_last = 4'b1111;
        #1;
        checks++;
        if (grant !== 4'b1000) begin
            failures++;
            $display("FAIL single_ptr_next grant=%b required 1000", grant);
        end
        tick();
    endtask

    task automatic test_rotation();
        logic [N-1:0] seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        req_valid = '1; req_last = '1; out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            randomize_data();
            #1;
            checks++;
            if (grant !== seq[c] || locked !== 1'b0) begin
                failures++;
                $display("FAIL rotation_%0d grant=%b locked=%b required %b/0", c, grant, locked, seq[c]);
            end
            tick();
        end
    endtask

    task automatic test_packet();
        req_valid = 4'b1000; req_last = 4'b1000; out_ready = 1'b1;
        tick();
        req_valid = 4'b0011;
        for (int b = 0; b < 3; b++) begin
            req_last = (b == 2) ? 4'b0011 : 4'b0010;
            randomize_data();
            #1;
            checks++;
            if (grant !== 4'b0001 || locked !== (b != 0) || out_last !== (b == 2) || out_data !== data_of(0)) begin
                failures++;
                $display("FAIL packet_beat%0d grant=%b locked=%b last=%b required 0001/%0d/%0d", b, grant, locked, out_last, b != 0, b == 2);
            end
            tick();
        end
        checks++;
        if (grant !== 4'b0010 || locked !== 1'b0) begin
            failures++;
            $display("FAIL packet_after grant=%b locked=%b required 0010/0", grant, locked);
        end
    endtask

    task automatic test_backpressure();
        req_valid = 4'b1001; req_last = 4'b1001; out_ready = 1'b0; randomize_data();
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++;
            if (req_ready !== 4'b0000 || grant !== 4'b1000 || out_data !== data_of(3) || out_valid !== 1'b1) begin
                failures++;
                $display("FAIL stall_%0d ready=%b grant=%b data=%h required 0000/1000/%h", c, req_ready, grant, out_data, data_of(3));
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b1000) begin
            failures++;
            $display("FAIL stall_release ready=%b required 1000", req_ready);
        end
        tick();
        #1;
        checks++;
        if (grant !== 4'b0001) begin
            failures++;
            $display("FAIL stall_ptr grant=%b required 0001", grant);
        end
    endtask

    task automatic test_owner_drop();
        req_valid = 4'b0010; req_last = 4'b0000; out_ready = 1'b1;
        tick();
        req_valid = 4'b0100; req_last = 4'b0100;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++;
            if (out_valid !== 1'b0 || grant !== 4'b0010 || locked !== 1'b1) begin
                failures++;
                $display("FAIL drop_%0d valid=%b grant=%b locked=%b required 0/0010/1", c, out_valid, grant, locked);
            end
            tick();
        end
        req_valid = 4'b0110; req_last = 4'b0110;
        #1;
        checks++;
        if (grant !== 4'b0010 || out_valid !== 1'b1 || out_last !== 1'b1) begin
            failures++;
            $display("FAIL drop_finish grant=%b valid=%b last=%b required 0010/1/1", grant, out_valid, out_last);
        end
        tick();
        req_valid = 4'b0100;
        #1;
        checks++;
        if (grant !== 4'b0100) begin
            failures++;
            $display("FAIL drop_next grant=%b required 0100", grant);
        end
    endtask

    task automatic test_reset_mid_packet();
        req_valid = 4'b0100; req_last = 4'b0000; out_ready = 1'b1;
        tick();
        checks++;
        if (locked !== 1'b1) begin
            failures++;
            $display("FAIL midreset_lock locked=%b required 1", locked);
        end
        reset = 1'b1; req_valid = 4'b1111; randomize_data();
        #1;
        checks++;
        if (grant !== '0 || req_ready !== '0 || out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== '0) begin
            failures++;
            $display("FAIL midreset_outputs grant=%b ready=%b valid=%b data=%h required zero", grant, req_ready, out_valid, out_data);
        end
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if (locked !== 1'b0 || grant !== 4'b0001) begin
            failures++;
            $display("FAIL midreset_after locked=%b grant=%b required 0/0001", locked, grant);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            int wi;
            logic [N-1:0] eg;
            logic         ev, el;
            logic [NB-1:0] ed;
            reset = ($urandom_range(0, 49) == 0);
            req_valid = N'($urandom());
            req_last = N'($urandom());
            out_ready = ($urandom_range(0, 3) != 0);
            randomize_data();
            #1;
            wi = m_winner();
            eg = (reset || wi < 0) ? '0 : N'(1) << wi;
            ev = (eg != 0) && req_valid[wi];
            el = (eg != 0) && req_last[wi];
            ed = (eg != 0) ? data_of(wi) : '0;
            checks++;
            if (grant !== eg || out_valid !== ev || out_last !== el || out_data !== ed ||
                req_ready !== (eg & {N{out_ready}}) || locked !== m_lock) begin
                failures++;
                $display("FAIL random_%0d grant=%b valid=%b last=%b locked=%b ready=%b required %b/%b/%b/%b/%b",
                         c, grant, out_valid, out_last, locked, req_ready, eg, ev, el, m_lock, eg & {N{out_ready}});
            end
            tick();
        end
    endtask

    initial begin
        reset = 1'b1; req_valid = '0; req_last = '0; req_data = '0; out_ready = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_rotation();
        test_packet();
        test_backpressure();
        test_owner_drop();
        test_reset_mid_packet();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
